aes_inv_key_expand: RTL and testbench

Reverse-direction AES key schedule for on-the-fly decryption. It is loaded with the last Nk words of the expanded schedule and regenerates the schedule backwards, one word per cycle. It presents round keys in decreasing order (round Nr down to round 0) on a valid/ready stream. It sits beside the inverse-cipher round engine, which consumes one round key per inverse round.

---
 rtl/aes_inv_key_expand_if.sv | 23 ++
 rtl/aes_inv_key_expand.sv | 127 ++++++++++++
 tb/tb_aes_inv_key_expand.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_key_expand_if.sv
// Round-key stream between the reverse key scheduler and the inverse-cipher round engine.
interface aes_inv_key_expand_if #(
    parameter int Nk = 4
);
    logic             start;
    logic [32*Nk-1:0] key_last;
    logic [127:0]     k_sch;
    logic [3:0]       rk_round;
    logic             rk_valid;
    logic             rk_ready;
    logic             busy;
    logic             done;

    modport master (
        output start, key_last, rk_ready,
        input  k_sch, rk_round, rk_valid, busy, done
    );

    modport slave (
        input  start, key_last, rk_ready,
        output k_sch, rk_round, rk_valid, busy, done
    );
endinterface

// File: rtl/aes_inv_key_expand.sv
// Reverse AES key schedule: regenerates one schedule word per cycle, round Nr valid one cycle after start.
// Round keys stream Nr..0 on valid/ready; stepping runs ahead until the window would lose an unaccepted round, then stalls.
module aes_inv_key_expand #(
    parameter int Nk = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_key_expand_if.slave  kif
);
    localparam int Nr = Nk + 6;
    localparam int W  = 4 * (Nr + 1);

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_t       state, state_nxt;
    logic [31:0]  win [Nk];
    logic [5:0]   b;
    logic [3:0]   rp;

    logic [6:0]   idx, imod, off;
    logic [3:0]   rc_idx;
    logic [31:0]  temp, new_w;
    logic         vld, hs, step;
    int           thr;
    logic [127:0] k_sel;

    // Undo w[i] = w[i-Nk] ^ f(w[i-1]) with i the top word of the window.
    always_comb begin
        idx    = {1'b0, b} + 7'(Nk - 1);
        imod   = idx % 7'(Nk);
        rc_idx = 4'(idx / 7'(Nk));
        temp   = win[Nk-2];
        if (imod == 7'd0)
            temp = sub_word({win[Nk-2][7:0], win[Nk-2][31:8]}) ^ {24'h0, RCON[rc_idx]};
        else if (Nk > 6 && imod == 7'd4)
            temp = sub_word(win[Nk-2]);
        new_w = win[Nk-1] ^ temp;
    end

    // A step must keep every word of the oldest round still owed to the consumer.
    always_comb begin
        vld  = (state == GEN) && ({1'b0, b} <= {1'b0, rp, 2'b00});
        hs   = vld && kif.rk_ready;
        thr  = 4 * (int'(rp) - int'(hs)) + 5 - Nk;
        step = (state == GEN) && (b != 6'd0) && (thr < 0 || int'(b) >= thr);
    end

    always_comb begin
        off   = {1'b0, rp, 2'b00} - {1'b0, b};
        k_sel = '0;
        for (int o = 0; o <= Nk - 4; o++)
            if (off == 7'(o))
                k_sel = {win[o+3], win[o+2], win[o+1], win[o]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (kif.start)
            state_nxt = GEN;
        else if (hs && rp == 4'd0)
            state_nxt = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < Nk; k++)
                win[k] <= '0;
            b  <= '0;
            rp <= '0;
        end else if (kif.start) begin
            for (int k = 0; k < Nk; k++)
                win[k] <= kif.key_last[32*k +: 32];
            b  <= 6'(W - Nk);
            rp <= 4'(Nr);
        end else begin
            if (step) begin
                win[0] <= new_w;
                for (int k = 1; k < Nk; k++)
                    win[k] <= win[k-1];
                b <= b - 6'd1;
            end
            if (hs && rp != 4'd0)
                rp <= rp - 4'd1;
        end
    end

    assign kif.k_sch    = k_sel;
    assign kif.rk_round = rp;
    assign kif.rk_valid = vld;
    assign kif.busy     = (state == GEN);
    assign kif.done     = (state == DONE);
endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Drives Nk=4/6/8 instances and scores the round-key stream against a forward FIPS-197 key expansion.
module tb_aes_inv_key_expand;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn_a  [3];
    logic         start_a [3];
    logic [255:0] key_a   [3];
    logic         ready_a [3];
    logic [127:0] ksch_a  [3];
    logic [3:0]   round_a [3];
    logic         valid_a [3];
    logic         busy_a  [3];
    logic         done_a  [3];
    logic [5:0]   b_a     [3];
    logic [3:0]   rp_a    [3];

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int NK = 4 + 2 * g;
        aes_inv_key_expand_if #(.Nk(NK)) kif ();
        assign kif.start    = start_a[g];
        assign kif.key_last = key_a[g][32*NK-1:0];
        assign kif.rk_ready = ready_a[g];
        assign ksch_a[g]    = kif.k_sch;
        assign round_a[g]   = kif.rk_round;
        assign valid_a[g]   = kif.rk_valid;
        assign busy_a[g]    = kif.busy;
        assign done_a[g]    = kif.done;
        assign b_a[g]       = dut.b;
        assign rp_a[g]      = dut.rp;
        aes_inv_key_expand #(.Nk(NK)) dut (.clk(clk), .rst_n(rstn_a[g]), .kif(kif));
    end

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_m [256];
    logic [7:0]   rcon_m [16];
    logic [31:0]  wm     [60];
    logic [127:0] got_k  [15];
    int           got_c  [15];

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rcon_m[0] = 8'h00;
        rcon_m[1] = 8'h01;
        for (int i = 2; i < 16; i++) rcon_m[i] = xtime(rcon_m[i-1]);
    endtask

    function automatic logic [31:0] subw_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // Forward key expansion from the cipher key.
    task automatic model_expand(input logic [255:0] key, input int nk);
        int wt;
        logic [31:0] t;
        wt = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) wm[i] = key[32*i +: 32];
        for (int i = nk; i < wt; i++) begin
            t = wm[i-1];
            if (i % nk == 0)
                t = subw_m({t[7:0], t[31:8]}) ^ {24'h0, rcon_m[i/nk]};
            else if (nk > 6 && i % nk == 4)
                t = subw_m(t);
            wm[i] = wm[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] expk(input int r);
        return {wm[4*r+3], wm[4*r+2], wm[4*r+1], wm[4*r]};
    endfunction

    function automatic logic [255:0] last_words(input int nk);
        logic [255:0] o = '0;
        int wt = 4 * (nk + 7);
        for (int k = 0; k < nk; k++) o[32*k +: 32] = wm[wt-nk+k];
        return o;
    endfunction

    function automatic logic [127:0] fips_to_ksch(input logic [127:0] f);
        logic [127:0] o;
        logic [31:0]  wd;
        for (int j = 0; j < 4; j++) begin
            wd = f[127-32*j -: 32];
            o[32*j +: 32] = {wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
        end
        return o;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] o;
        for (int k = 0; k < 8; k++) o[32*k +: 32] = $urandom;
        return o;
    endfunction

    // Called at a falling edge; start is sampled at the next rising edge (cycle 0).
    task automatic run(input int sel, input logic [255:0] kl, input int pct, input int abort_round,
                       input int abort_cyc, input bit chk_timing, output bit aborted);
        int nk, nr, wt, exp_r, stab_bad, floor_bad;
        bit pv, prdy, r0_seen, fin;
        logic [127:0] pk;
        logic [3:0]   pr;
        nk = 4 + 2 * sel; nr = nk + 6; wt = 4 * (nr + 1);
        exp_r = nr; stab_bad = 0; floor_bad = 0;
        pv = 1'b0; prdy = 1'b0; r0_seen = 1'b0; fin = 1'b0; aborted = 1'b0;
        pk = '0; pr = '0;
        key_a[sel]   = kl;
        start_a[sel] = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
            @(negedge clk);
            start_a[sel] = 1'b0;
            ready_a[sel] = ($urandom_range(99) < pct);
            if (cyc == abort_cyc || (abort_round >= 0 && valid_a[sel] && int'(round_a[sel]) == abort_round)) begin
                aborted = 1'b1;
                return;
            end
            if (cyc == 1)
                check("first_key", 160'({valid_a[sel], round_a[sel], ksch_a[sel]}),
                      160'({1'b1, 4'(nr), expk(nr)}));
            if (r0_seen) begin
                check("done_state", 160'({done_a[sel], busy_a[sel], valid_a[sel]}), 160'(3'b100));
                fin = 1'b1;
            end else begin
                if (pv && !prdy && (!valid_a[sel] || ksch_a[sel] != pk || round_a[sel] != pr))
                    stab_bad++;
                if (sel == 2 && busy_a[sel] && int'(b_a[sel]) < 4 * int'(rp_a[sel]) + 4 - nk)
                    floor_bad++;
                if (valid_a[sel] && ready_a[sel]) begin
                    check("round_key", 160'({round_a[sel], ksch_a[sel]}), 160'({4'(exp_r), expk(exp_r)}));
                    got_k[exp_r] = ksch_a[sel];
                    got_c[exp_r] = cyc;
                    if (exp_r == 0) begin
                        r0_seen = 1'b1;
                        if (chk_timing) check("r0_cycle", 160'(cyc), 160'(1 + wt - nk));
                    end else begin
                        exp_r--;
                    end
                end
                pv = valid_a[sel]; prdy = ready_a[sel]; pk = ksch_a[sel]; pr = round_a[sel];
            end
        end
        check("finished", 160'(fin), 160'(1));
        if (pct < 100) check("stable_stall", 160'(stab_bad), 160'(0));
        if (sel == 2) check("b_floor", 160'(floor_bad), 160'(0));
    endtask

    typedef struct {
        int           rnd;
        logic [127:0] fips;
        int           cyc;
    } vec_t;

    vec_t tv [3];
    bit   ab;

    initial begin
        tv[0] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1};
        tv[1] = '{9,  128'hac7766f319fadc2128d12941575c006e, 5};
        tv[2] = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 41};

        build_tables();
        for (int g = 0; g < 3; g++) begin
            rstn_a[g] = 1'b1; start_a[g] = 1'b0; ready_a[g] = 1'b1; key_a[g] = '0;
        end
        #1;
        for (int g = 0; g < 3; g++) rstn_a[g] = 1'b0;
        #12;
        for (int g = 0; g < 3; g++)
            check("reset_out", 160'({ksch_a[g], round_a[g], valid_a[g], busy_a[g], done_a[g]}), 160'(0));
        @(negedge clk);
        for (int g = 0; g < 3; g++) rstn_a[g] = 1'b1;
        @(negedge clk);

        // FIPS-197 AES-128 known answer
        model_expand({128'h0, fips_to_ksch(tv[2].fips)}, 4);
        run(0, {128'h0, fips_to_ksch(tv[0].fips)}, 100, -1, -1, 1'b1, ab);
        for (int i = 0; i < 3; i++) begin
            check("fips_key", 160'(got_k[tv[i].rnd]), 160'(fips_to_ksch(tv[i].fips)));
            check("fips_cycle", 160'(got_c[tv[i].rnd]), 160'(tv[i].cyc));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("done_hold", 160'({valid_a[0], done_a[0], busy_a[0]}), 160'(3'b010));
        end

        // Random keys, Nk=6 and Nk=8, ready held high
        for (int s = 1; s < 3; s++) begin
            model_expand(rand_key(), 4 + 2 * s);
            @(negedge clk);
            run(s, last_words(4 + 2 * s), 100, -1, -1, 1'b1, ab);
        end

        // Backpressure, Nk=8
        for (int n = 0; n < 2; n++) begin
            model_expand(rand_key(), 8);
            @(negedge clk);
            run(2, last_words(8), 30, -1, -1, 1'b0, ab);
        end

        // Restart while round 5 is presented
        model_expand(rand_key(), 4);
        @(negedge clk);
        run(0, last_words(4), 100, 5, -1, 1'b0, ab);
        check("abort_hit", 160'(ab), 160'(1));
        model_expand(rand_key(), 4);
        run(0, last_words(4), 100, -1, -1, 1'b1, ab);

        // Async reset at cycle 20, Nk=6
        model_expand(rand_key(), 6);
        @(negedge clk);
        run(1, last_words(6), 100, -1, 20, 1'b0, ab);
        rstn_a[1] = 1'b0;
        #1;
        check("reset_mid", 160'({ksch_a[1], round_a[1], valid_a[1], busy_a[1], done_a[1]}), 160'(0));
        @(negedge clk);
        rstn_a[1] = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 160'({valid_a[1], busy_a[1], done_a[1]}), 160'(0));
        model_expand(rand_key(), 6);
        run(1, last_words(6), 100, -1, -1, 1'b1, ab);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
